// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame sequencer driving an ALU
//
// Collects HEADER, opcode, operand A, operand B (and a checksum byte when
// UART_CMD_CHECKSUM_EN is defined) from the UART receiver. It validates the
// frame, starts the ALU, waits for completion and latches the result. Idle
// gaps between bytes and ALU hangs are bounded by TIMEOUT_CLKS.
//
// Optional feature macro: UART_CMD_CHECKSUM_EN (adds the checksum byte/GET_CK)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rx_data, rx_valid         received byte and its one-cycle strobe
//   alu_op, alu_a, alu_b      ALU operands (held from EXEC until next frame)
//   alu_start                 one-cycle ALU start pulse
//   alu_done, alu_result      ALU completion strobe and result
//   result, result_valid      last good result and its update pulse
//   busy                      high whenever a frame is in progress
//   err, err_code             error pulse; 01 timeout, 10 checksum, 11 opcode

module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_CLKS = 50000,
    parameter int         CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CK,
        EXEC,
        WAIT_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CODE_CHECKSUM = 2'b10;
    localparam logic [1:0] CODE_OPCODE   = 2'b11;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       op_r;
    logic [7:0]       a_r;
    logic [7:0]       b_r;

    logic             load_op;
    logic             load_a;
    logic             load_b;
    logic             load_result;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             err_set;
    logic [1:0]       err_code_set;
    logic             at_limit;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       ck_calc;
    assign ck_calc = op_r ^ a_r ^ b_r;
`endif

    assign at_limit  = (cnt == LIMIT);
    assign alu_op    = op_r[3:0];
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_start = (state == EXEC);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A received byte or ALU completion always takes priority over the
    // timeout check in the same cycle.
    always_comb begin
        state_next   = state;
        load_op      = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_result  = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        err_set      = 1'b0;
        err_code_set = CODE_TIMEOUT;

        case (state)
            IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_next = GET_OP;
                end
            end
            GET_OP, GET_A, GET_B, GET_CK: begin
                if (rx_valid) begin
                    cnt_clr = 1'b1;
                    case (state)
                        GET_OP: begin
                            load_op    = 1'b1;
                            state_next = GET_A;
                        end
                        GET_A: begin
                            load_a     = 1'b1;
                            state_next = GET_B;
                        end
                        GET_B: begin
                            load_b = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                            state_next = GET_CK;
`else
                            if (op_r[7:4] != 4'd0) begin
                                err_set      = 1'b1;
                                err_code_set = CODE_OPCODE;
                                state_next   = IDLE;
                            end else begin
                                state_next = EXEC;
                            end
`endif
                        end
                        default: begin
`ifdef UART_CMD_CHECKSUM_EN
                            if (rx_data != ck_calc) begin
                                err_set      = 1'b1;
                                err_code_set = CODE_CHECKSUM;
                                state_next   = IDLE;
                            end else if (op_r[7:4] != 4'd0) begin
                                err_set      = 1'b1;
                                err_code_set = CODE_OPCODE;
                                state_next   = IDLE;
                            end else begin
                                state_next = EXEC;
                            end
`else
                            state_next = IDLE;
`endif
                        end
                    endcase
                end else if (at_limit) begin
                    err_set      = 1'b1;
                    err_code_set = CODE_TIMEOUT;
                    state_next   = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            EXEC: begin
                // A done that arrives together with the start still completes.
                if (alu_done) begin
                    load_result = 1'b1;
                    state_next  = IDLE;
                end else begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (alu_done) begin
                    load_result = 1'b1;
                    state_next  = IDLE;
                end else if (at_limit) begin
                    err_set      = 1'b1;
                    err_code_set = CODE_TIMEOUT;
                    state_next   = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            op_r         <= 8'd0;
            a_r          <= 8'd0;
            b_r          <= 8'd0;
            result       <= 8'd0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            if (cnt_clr || state_next != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (load_op) begin
                op_r <= rx_data;
            end
            if (load_a) begin
                a_r <= rx_data;
            end
            if (load_b) begin
                b_r <= rx_data;
            end
            if (load_result) begin
                result <= alu_result;
            end
            result_valid <= load_result;
            err          <= err_set;
            if (err_set) begin
                err_code <= err_code_set;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl

module tb_uart_cmd_ctrl;

    localparam int         T   = 40;
    localparam logic [7:0] HDR = 8'hA5;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic       alu_done;
    logic [7:0] alu_result;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    uart_cmd_ctrl #(
        .HEADER      (HDR),
        .TIMEOUT_CLKS(T),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ck;
        logic [7:0] alu_res;
        bit         ok;
        logic [1:0] code;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] ck, logic [7:0] alu_res, bit ok,
                                logic [1:0] code, logic [7:0] exp_res);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.ck = ck; v.alu_res = alu_res;
        v.ok = ok; v.code = code; v.exp_res = exp_res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input vec_t v);
        send_byte(HDR);
        send_byte(v.op);
        send_byte(v.a);
        send_byte(v.b);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(v.ck);
`endif
    endtask

    task automatic expect_ok(input vec_t v, input string tag);
        chk({tag, "_start"}, alu_start, 1'b1);
        chk({tag, "_op"}, alu_op, v.op[3:0]);
        chk({tag, "_a"}, alu_a, v.a);
        chk({tag, "_b"}, alu_b, v.b);
        chk({tag, "_busy"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_start_1cyc"}, alu_start, 1'b0);
        @(negedge clk);
        alu_done   = 1'b1;
        alu_result = v.alu_res;
        @(negedge clk);
        alu_done = 1'b0;
        chk({tag, "_rv"}, result_valid, 1'b1);
        chk({tag, "_result"}, result, v.exp_res);
        chk({tag, "_busy_low"}, busy, 1'b0);
        chk({tag, "_no_err"}, err, 1'b0);
        @(negedge clk);
        chk({tag, "_rv_pulse"}, result_valid, 1'b0);
    endtask

    task automatic expect_err(input vec_t v, input string tag);
        chk({tag, "_err"}, err, 1'b1);
        chk({tag, "_code"}, err_code, v.code);
        chk({tag, "_no_start"}, alu_start, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_result"}, result, v.exp_res);
        @(negedge clk);
        chk({tag, "_err_pulse"}, err, 1'b0);
        chk({tag, "_code_held"}, err_code, v.code);
    endtask

    initial begin
        int n;
        vec_t v;

        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        alu_done   = 1'b0;
        alu_result = 8'h00;

        vecs.push_back(mk(8'h01, 8'h12, 8'h34, 8'h27, 8'h46, 1'b1, 2'b00, 8'h46));
`ifdef UART_CMD_CHECKSUM_EN
        vecs.push_back(mk(8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 2'b10, 8'h46));
`endif
        vecs.push_back(mk(8'h21, 8'h00, 8'h00, 8'h21, 8'h00, 1'b0, 2'b11, 8'h46));
        vecs.push_back(mk(8'h0F, 8'hFF, 8'h00, 8'hF0, 8'hAB, 1'b1, 2'b00, 8'hAB));
        vecs.push_back(mk(8'h10, 8'h00, 8'h00, 8'h10, 8'h00, 1'b0, 2'b11, 8'hAB));
        vecs.push_back(mk(8'h0A, 8'hA5, 8'hA5, 8'h0A, 8'h5A, 1'b1, 2'b00, 8'h5A));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'b00, 8'h00));

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op", alu_op, 4'h0);
        chk("rst_a", alu_a, 8'h00);
        chk("rst_b", alu_b, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_code", err_code, 2'b00);
        chk("rst_pulses", {alu_start, result_valid, err}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            send_frame(vecs[i]);
            if (vecs[i].ok) expect_ok(vecs[i], $sformatf("vec%0d", i));
            else            expect_err(vecs[i], $sformatf("vec%0d", i));
        end

        // Inter-byte timeout, then a normal frame.
        send_byte(HDR);
        send_byte(8'h01);
        n = 0;
        while (!err && n < T + 5) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, T);
        chk("to_code", err_code, 2'b01);
        chk("to_busy", busy, 1'b0);
        chk("to_result", result, 8'h00);
        @(negedge clk);
        v = mk(8'h01, 8'h12, 8'h34, 8'h27, 8'h46, 1'b1, 2'b00, 8'h46);
        send_frame(v);
        expect_ok(v, "after_to");

        // Byte arriving in the very cycle the count reaches its limit wins.
        send_byte(HDR);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h02);
        chk("lim_byte_no_err", err, 1'b0);
        chk("lim_byte_busy", busy, 1'b1);
        send_byte(8'h03);
        send_byte(8'h04);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h05);
`endif
        expect_ok(mk(8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 1'b1, 2'b00, 8'h07), "lim_byte");

        // ALU never answers.
        v = mk(8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 1'b1, 2'b00, 8'h00);
        send_frame(v);
        chk("hang_start", alu_start, 1'b1);
        n = 0;
        while (!err && n < T + 10) begin
            @(negedge clk);
            n++;
            if (result_valid) chk("hang_no_rv", result_valid, 1'b0);
        end
        chk("hang_latency", n, T + 1);
        chk("hang_code", err_code, 2'b01);
        chk("hang_busy", busy, 1'b0);
        chk("hang_result", result, 8'h07);
        @(negedge clk);

        // Done coincides with the wait limit; next header lands as busy falls.
        send_frame(mk(8'h0F, 8'hFF, 8'h00, 8'hF0, 8'h00, 1'b1, 2'b00, 8'h00));
        chk("dlim_start", alu_start, 1'b1);
        repeat (T) @(negedge clk);
        alu_done   = 1'b1;
        alu_result = 8'hAB;
        @(negedge clk);
        alu_done = 1'b0;
        chk("dlim_rv", result_valid, 1'b1);
        chk("dlim_no_err", err, 1'b0);
        chk("dlim_result", result, 8'hAB);
        chk("dlim_busy", busy, 1'b0);
        send_byte(HDR);
        chk("back2back_busy", busy, 1'b1);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h27);
`endif
        expect_ok(mk(8'h01, 8'h12, 8'h34, 8'h27, 8'h46, 1'b1, 2'b00, 8'h46), "back2back");

        // Byte during WAIT_DONE is dropped.
        send_frame(mk(8'h0F, 8'hFF, 8'h00, 8'hF0, 8'h00, 1'b1, 2'b00, 8'h00));
        chk("drop_start", alu_start, 1'b1);
        @(negedge clk);
        send_byte(8'hFF);
        chk("drop_busy", busy, 1'b1);
        chk("drop_a", alu_a, 8'hFF);
        chk("drop_b", alu_b, 8'h00);
        alu_done   = 1'b1;
        alu_result = 8'h77;
        @(negedge clk);
        alu_done = 1'b0;
        chk("drop_rv", result_valid, 1'b1);
        chk("drop_result", result, 8'h77);
        chk("drop_busy_low", busy, 1'b0);

        // Reset in GET_A, noise in IDLE, late done ignored.
        @(negedge clk);
        send_byte(HDR);
        send_byte(8'h09);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_op", alu_op, 4'h0);
        chk("arst_result", result, 8'h00);
        chk("arst_code", err_code, 2'b00);
        chk("arst_pulses", {alu_start, result_valid, err}, 3'b000);
        @(negedge clk);
        chk("arst_no_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h00);
        chk("noise00_busy", busy, 1'b0);
        send_byte(8'h5A);
        chk("noise5a_busy", busy, 1'b0);
        alu_done   = 1'b1;
        alu_result = 8'h99;
        @(negedge clk);
        alu_done = 1'b0;
        chk("late_done_rv", result_valid, 1'b0);
        chk("late_done_result", result, 8'h00);
        v = mk(8'h01, 8'h12, 8'h34, 8'h27, 8'h46, 1'b1, 2'b00, 8'h46);
        send_frame(v);
        expect_ok(v, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

- Command sequencer between the 8-bit UART receiver and the ALU.
- Assembles received bytes into command frames: header, opcode, operand A, operand B and, optionally, a checksum.
- Checks each frame, then drives the ALU with a start/done handshake and latches the result.
- Reports timeout, checksum and opcode errors with a one-cycle error strobe and a code.

## Interface

Parameters:
- `HEADER`, 8'hA5, frame start byte.
- `TIMEOUT_CLKS`, 50000, maximum idle clocks between frame bytes, and maximum wait for `alu_done` (1 ms at 50 MHz).
- `CNT_W`, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CLKS.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  single-cycle strobe, one per received byte.
- `alu_op`  out  4  ALU opcode.
- `alu_a`  out  8  ALU operand A.
- `alu_b`  out  8  ALU operand B.
- `alu_start`  out  1  one-cycle ALU start pulse.
- `alu_done`  in  1  ALU completion strobe.
- `alu_result`  in  8  ALU result; sampled when `alu_done` is high.
- `result`  out  8  last successful result, held until the next one.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error cause: 01 timeout, 10 checksum, 11 bad opcode; held until the next `err`.

## Operation

States: IDLE, GET_OP, GET_A, GET_B, GET_CK, EXEC, WAIT_DONE.

- IDLE: `rx_valid` with `rx_data == HEADER` → GET_OP. Any other byte is ignored.
- GET_OP / GET_A / GET_B: each `rx_valid` stores the byte into the opcode, A or B register and advances one state. GET_B → GET_CK.
- GET_CK: the byte is compared against `op ^ a ^ b`.
  - Mismatch → `err`, code 10, → IDLE.
  - Match and `op[7:4] != 0` → `err`, code 11, → IDLE.
  - Otherwise → EXEC.
- EXEC: `alu_start` is high for exactly one cycle, then the FSM goes to WAIT_DONE. An `alu_done` sampled in EXEC counts as completion.
- WAIT_DONE: on `alu_done`:
  - `result <= alu_result`;
  - `result_valid` pulses;
  - the FSM returns to IDLE.
- Operand outputs:
  - `alu_op = op[3:0]`, `alu_a` and `alu_b` come straight from their registers.
  - They are stable from EXEC until the next frame overwrites them.
- Timeout counter:
  - Cleared on every state change and on every accepted byte.
  - Increments each cycle in GET_* states and in WAIT_DONE.
  - On reaching `TIMEOUT_CLKS-1` → `err`, code 01, → IDLE. The partial frame is discarded; `result` is unchanged.
- Bytes arriving in EXEC or WAIT_DONE are dropped.
- There is no resync: a HEADER value received mid-frame is treated as data.

## Timing

- Reset values:
  - State IDLE.
  - `alu_op`, `alu_a`, `alu_b`, `result` = 0; `err_code` = 00.
  - `alu_start`, `result_valid`, `err`, `busy` = 0.
  - Counter 0.
- Reset asserted mid-frame or in WAIT_DONE aborts immediately with no `err` pulse. A late `alu_done` after reset is ignored.
- Latency:
  - Last frame byte accepted at cycle t → `alu_start` high at t+1.
  - `alu_done` at cycle d → `result`/`result_valid` at d+1, `busy` low at d+1.
- Errors: `err`/`err_code` update in the cycle after the offending byte or the timeout count.
- `rx_valid` in the same cycle the counter hits its limit: the byte wins, the counter clears and no timeout occurs.
- `alu_done` in the same cycle as the WAIT_DONE limit: completion wins.
- A new frame may begin in the cycle `busy` falls.

## Configuration

- `UART_CMD_CHECKSUM_EN` defined:
  - The frame is 5 bytes and GET_CK exists.
  - Checksum and opcode checks run in GET_CK.
- Not defined:
  - The frame is 4 bytes; GET_B transitions directly to the check.
  - The opcode check runs on the B byte cycle.
  - Error code 10 is never produced.

## Test plan

- Valid frame: send A5 01 12 34 27, ALU returns 0x46 after 3 cycles → one `alu_start` with op=1, a=12, b=34; then `result`=46 and a `result_valid` pulse.
- Checksum mismatch: send A5 01 12 34 00 → `err`, `err_code`=10, no `alu_start`, `result` unchanged.
- Bad opcode: send A5 21 00 00 21 → `err`, `err_code`=11.
- Inter-byte timeout: send A5 01, then silence for 50000 clocks → `err`, code 01, `busy`=0. A following valid frame executes normally.
- ALU hang and bytes during execution:
  - Withhold `alu_done` → timeout with code 01.
  - In a separate frame, send 0xFF in WAIT_DONE → the byte is dropped and the frame result is correct.
- Reset in GET_A: assert `rst` → all outputs return to reset values immediately, with no `err` pulse. Noise bytes 00 and 5A in IDLE → ignored.
